// File: rtl/seq_nr_divider_if.sv
// Handshake and operand/result bundle for the sequential non-restoring divider.
// The master side supplies operands and takes results; the slave side is the divider.
interface seq_nr_divider_if #(
  parameter int unsigned N = 8
) ();
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;
  logic         busy;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, busy
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, busy
  );
endinterface

// File: rtl/seq_nr_divider.sv
// Sequential unsigned non-restoring divider: one shared (N+1)-bit adder, one quotient bit
// per cycle, a fixed correction cycle, and valid/ready handshakes on both sides.
module seq_nr_divider #(
  parameter int unsigned N = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_nr_divider_if.slave   bus
);

  localparam int unsigned CntW = $clog2(N);
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [N:0]      r_q, r_d;
  logic [N-1:0]    q_q, q_d;
  logic [N-1:0]    d_q, d_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    quot_q, quot_d;
  logic [N-1:0]    rem_q, rem_d;
  logic            dbz_q, dbz_d;
  logic            in_ready_q, in_ready_d;

  logic [N:0] add_a, add_b, sum;
  logic       sub;

  // The single adder serves both the CALC iterations and the FIX correction.
  always_comb begin
    sub   = (state_q == StCalc) && !r_q[N];
    add_a = (state_q == StFix) ? r_q : {r_q[N-1:0], q_q[N-1]};
    add_b = sub ? ~{1'b0, d_q} : {1'b0, d_q};
    sum   = add_a + add_b + {{N{1'b0}}, sub};
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid && in_ready_q) begin
          d_d   = bus.divisor;
          q_d   = bus.dividend;
          r_d   = '0;
          cnt_d = '0;
          if (bus.divisor == '0) begin
            quot_d  = '1;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        r_d   = sum;
        q_d   = {q_q[N-2:0], ~sum[N]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StFix;
        end
      end
      StFix: begin
        // A negative final remainder gets the divisor added back once.
        if (r_q[N]) begin
          r_d = sum;
        end
        quot_d  = q_q;
        rem_d   = r_q[N] ? sum[N-1:0] : r_q[N-1:0];
        dbz_d   = 1'b0;
        state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Ready only after a full cycle in IDLE, so a result hand-off never re-accepts same cycle.
    in_ready_d = (state_q == StIdle) && (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      r_q        <= '0;
      q_q        <= '0;
      d_q        <= '0;
      cnt_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      q_q        <= q_d;
      d_q        <= d_d;
      cnt_q      <= cnt_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      dbz_q      <= dbz_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = (state_q == StDone);
  assign bus.busy        = (state_q == StCalc) || (state_q == StFix);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_nr_divider.sv
// Directed bench for seq_nr_divider: reset, basic and corner divisions, divide by zero,
// back-pressure, mid-operation reset and a back-to-back random sweep against a/b and a%b.
module tb_seq_nr_divider;
  localparam int unsigned N = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_nr_divider_if #(.N(N)) bus ();

  seq_nr_divider #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int n_results = 0;

  always @(posedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) n_results++;
  end

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, output bit ok);
    int w = 0;
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    ok = bus.in_ready;
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // lat counts edges after the accept edge until out_valid is seen.
  task automatic wait_valid(output int lat, output int busy_cyc);
    lat = 0;
    busy_cyc = 0;
    while (!bus.out_valid && lat < 50) begin
      if (bus.busy) busy_cyc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.div_by_zero} !== 4'b1000) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 1000",
               {bus.in_ready, bus.out_valid, bus.busy, bus.div_by_zero});
    end
    total++;
    if (bus.quotient !== 8'd0) begin
      bad++; $display("FAIL reset_quot: got %0d want 0", bus.quotient);
    end
    total++;
    if (bus.remainder !== 8'd0) begin
      bad++; $display("FAIL reset_rem: got %0d want 0", bus.remainder);
    end
  endtask

  task automatic test_basic();
    bit ok; int lat, bc;
    send(8'd100, 8'd7, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_accept: got in_ready 0 want 1"); end
    wait_valid(lat, bc);
    total++;
    if (lat != 9) begin bad++; $display("FAIL basic_lat: got %0d want 9", lat); end
    total++;
    if (bc != 9) begin bad++; $display("FAIL basic_busy: got %0d want 9", bc); end
    total++;
    if (bus.quotient !== 8'd14) begin
      bad++; $display("FAIL basic_quot: got %0d want 14", bus.quotient);
    end
    total++;
    if (bus.remainder !== 8'd2) begin
      bad++; $display("FAIL basic_rem: got %0d want 2", bus.remainder);
    end
    total++;
    if (bus.div_by_zero !== 1'b0) begin
      bad++; $display("FAIL basic_dbz: got %b want 0", bus.div_by_zero);
    end
    take();
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b00) begin
      bad++; $display("FAIL basic_release: got %b want 00", {bus.out_valid, bus.in_ready});
    end
    @(negedge clk);
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL basic_rearm: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_corners();
    logic [N-1:0] va [5] = '{8'd255, 8'd5, 8'd255, 8'd0,  8'd254};
    logic [N-1:0] vb [5] = '{8'd1,   8'd9, 8'd255, 8'd13, 8'd255};
    logic [N-1:0] vq [5] = '{8'd255, 8'd0, 8'd1,   8'd0,  8'd0};
    logic [N-1:0] vr [5] = '{8'd0,   8'd5, 8'd0,   8'd0,  8'd254};
    for (int i = 0; i < 5; i++) begin
      bit ok; int lat, bc;
      send(va[i], vb[i], ok);
      wait_valid(lat, bc);
      total++;
      if (lat != 9) begin bad++; $display("FAIL corner%0d_lat: got %0d want 9", i, lat); end
      total++;
      if (bus.quotient !== vq[i]) begin
        bad++; $display("FAIL corner%0d_quot: got %0d want %0d", i, bus.quotient, vq[i]);
      end
      total++;
      if (bus.remainder !== vr[i]) begin
        bad++; $display("FAIL corner%0d_rem: got %0d want %0d", i, bus.remainder, vr[i]);
      end
      take();
    end
  endtask

  task automatic test_div_zero();
    bit ok; int lat, bc;
    send(8'h5A, 8'h00, ok);
    wait_valid(lat, bc);
    total++;
    if (lat != 0) begin bad++; $display("FAIL dbz_lat: got %0d want 0", lat); end
    total++;
    if (bus.quotient !== 8'hFF) begin
      bad++; $display("FAIL dbz_quot: got %h want ff", bus.quotient);
    end
    total++;
    if (bus.remainder !== 8'h5A) begin
      bad++; $display("FAIL dbz_rem: got %h want 5a", bus.remainder);
    end
    total++;
    if (bus.div_by_zero !== 1'b1) begin
      bad++; $display("FAIL dbz_flag: got %b want 1", bus.div_by_zero);
    end
    take();
    send(8'd9, 8'd4, ok);
    wait_valid(lat, bc);
    total++;
    if ({bus.div_by_zero, bus.quotient, bus.remainder} !== {1'b0, 8'd2, 8'd1}) begin
      bad++; $display("FAIL dbz_clear: got dbz=%b q=%0d r=%0d want dbz=0 q=2 r=1",
                      bus.div_by_zero, bus.quotient, bus.remainder);
    end
    take();
  endtask

  task automatic test_backpressure();
    bit ok; int lat, bc;
    send(8'd77, 8'd5, ok);
    wait_valid(lat, bc);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.dividend = 8'd3;
      bus.divisor  = 8'd1;
      @(negedge clk);
      total++;
      if ({bus.out_valid, bus.in_ready, bus.quotient, bus.remainder} !==
          {1'b1, 1'b0, 8'd15, 8'd2}) begin
        bad++; $display("FAIL bp_hold%0d: got v=%b rdy=%b q=%0d r=%0d want v=1 rdy=0 q=15 r=2",
                        i, bus.out_valid, bus.in_ready, bus.quotient, bus.remainder);
      end
    end
    bus.in_valid = 1'b0;
    take();
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b00) begin
      bad++; $display("FAIL bp_release: got %b want 00", {bus.out_valid, bus.in_ready});
    end
    @(negedge clk);
    total++;
    if ({bus.in_ready, bus.busy, bus.out_valid} !== 3'b100) begin
      bad++; $display("FAIL bp_rearm: got %b want 100", {bus.in_ready, bus.busy, bus.out_valid});
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int lat, bc;
    send(8'd200, 8'd3, ok);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.div_by_zero, bus.quotient, bus.remainder}
        !== {4'b1000, 8'd0, 8'd0}) begin
      bad++; $display("FAIL midrst_state: got rdy=%b v=%b busy=%b q=%0d r=%0d want 1 0 0 0 0",
                      bus.in_ready, bus.out_valid, bus.busy, bus.quotient, bus.remainder);
    end
    send(8'd200, 8'd3, ok);
    wait_valid(lat, bc);
    total++;
    if (lat != 9) begin bad++; $display("FAIL midrst_lat: got %0d want 9", lat); end
    total++;
    if ({bus.quotient, bus.remainder} !== {8'd66, 8'd2}) begin
      bad++; $display("FAIL midrst_result: got q=%0d r=%0d want q=66 r=2",
                      bus.quotient, bus.remainder);
    end
    take();
  endtask

  task automatic test_back_to_back();
    int base;
    base = n_results;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      bit ok; int lat, bc;
      logic [N-1:0] a, b;
      a = N'($urandom_range(0, 255));
      b = N'($urandom_range(1, 255));
      send(a, b, ok);
      wait_valid(lat, bc);
      total++;
      if (!ok || lat != 9) begin
        bad++; $display("FAIL sweep%0d_timing: got ok=%b lat=%0d want ok=1 lat=9", i, ok, lat);
      end
      total++;
      if (bus.quotient !== a / b || bus.remainder !== a % b) begin
        bad++; $display("FAIL sweep%0d_result: %0d/%0d got q=%0d r=%0d want q=%0d r=%0d",
                        i, a, b, bus.quotient, bus.remainder, a / b, a % b);
      end
      total++;
      if ((int'(bus.quotient) * int'(b) + int'(bus.remainder)) != int'(a) ||
          bus.remainder >= b) begin
        bad++; $display("FAIL sweep%0d_invariant: %0d/%0d got q=%0d r=%0d",
                        i, a, b, bus.quotient, bus.remainder);
      end
    end
    @(negedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    total++;
    if (n_results - base != 1000) begin
      bad++; $display("FAIL sweep_count: got %0d want 1000", n_results - base);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_corners();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
